// File: rtl/tone_period_decoder_if.sv
// Bundle of the tone input and the decoded-note outputs shared between the
// decoder (slave side) and whatever drives the pin and consumes the note.
interface tone_period_decoder_if;
  logic        tone_in;
  logic [3:0]  note_code;
  logic        note_valid;
  logic        note_strobe;
  logic [31:0] period_meas;

  modport master (
    output tone_in,
    input  note_code,
    input  note_valid,
    input  note_strobe,
    input  period_meas
  );

  modport slave (
    input  tone_in,
    output note_code,
    output note_valid,
    output note_strobe,
    output period_meas
  );
endinterface

// File: rtl/tone_period_decoder.sv
// Measures the rising-to-rising period of a square-wave tone and decodes it to
// the keypad button code; a code is confirmed after two consecutive matches.
module tone_period_decoder #(
  parameter int unsigned TOL         = 256,
  parameter int unsigned SILENCE_CYC = 200000
) (
  input  logic                 clk,
  input  logic                 rst,
  tone_period_decoder_if.slave bus
);

  typedef enum logic [1:0] {SILENT, FIRST, TRACK} state_t;

  localparam logic [31:0] TOL_W = 32'(TOL);
  localparam logic [31:0] SIL_W = 32'(SILENCE_CYC);

  localparam logic [31:0] NOMINAL [1:15] = '{
    32'd95557, 32'd85131, 32'd75843, 32'd71607, 32'd63776,
    32'd56818, 32'd50619, 32'd47778, 32'd42564, 32'd37922,
    32'd35794, 32'd31888, 32'd28409, 32'd25310, 32'd23889
  };

  state_t      state_q, state_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        tone_dly_q, tone_dly_d;
  logic [31:0] pcnt_q, pcnt_d;
  logic [31:0] period_meas_q, period_meas_d;
  logic        eval_q, eval_d;
  logic [3:0]  cand_q, cand_d;
  logic [3:0]  note_code_q, note_code_d;
  logic        note_valid_q, note_valid_d;
  logic        note_strobe_q, note_strobe_d;

  logic        rise_edge;
  logic [15:1] hit;
  logic [31:0] diff [1:15];
  logic [3:0]  match;

  assign rise_edge = sync2_q & ~tone_dly_q;

  genvar gi;
  generate
    for (gi = 1; gi <= 15; gi++) begin : g_cmp
      assign diff[gi] = (period_meas_q >= NOMINAL[gi]) ? (period_meas_q - NOMINAL[gi])
                                                       : (NOMINAL[gi] - period_meas_q);
      assign hit[gi]  = (diff[gi] <= TOL_W);
    end
  endgenerate

  // Table spacing guarantees at most one hit, so OR-ing the indices is exact.
  always_comb begin
    match = 4'd0;
    for (int k = 1; k <= 15; k++) begin
      if (hit[k]) match = match | 4'(k);
    end
  end

  always_comb begin
    state_d       = state_q;
    sync1_d       = bus.tone_in;
    sync2_d       = sync1_q;
    tone_dly_d    = sync2_q;
    period_meas_d = period_meas_q;
    eval_d        = 1'b0;
    cand_d        = cand_q;
    note_code_d   = note_code_q;
    note_valid_d  = note_valid_q;
    note_strobe_d = 1'b0;

    if (rise_edge) begin
      pcnt_d = 32'd1;
    end else if (pcnt_q == SIL_W) begin
      pcnt_d = pcnt_q;
    end else begin
      pcnt_d = pcnt_q + 32'd1;
    end

    case (state_q)
      SILENT: begin
        if (rise_edge) state_d = FIRST;
      end
      FIRST, TRACK: begin
        if (rise_edge) begin
          period_meas_d = pcnt_q;
          eval_d        = 1'b1;
          state_d       = TRACK;
        end else if (pcnt_q == SIL_W) begin
          state_d       = SILENT;
          note_code_d   = 4'd0;
          note_valid_d  = 1'b0;
          cand_d        = 4'd0;
          note_strobe_d = (note_code_q != 4'd0);
        end
      end
      default: state_d = SILENT;
    endcase

    // Evaluation runs on the period captured in the previous cycle.
    if (eval_q) begin
      if (match == 4'd0) begin
        cand_d = 4'd0;
      end else if (match != cand_q) begin
        cand_d = match;
      end else begin
        note_code_d   = match;
        note_valid_d  = 1'b1;
        note_strobe_d = (match != note_code_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= SILENT;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      tone_dly_q    <= 1'b0;
      pcnt_q        <= 32'd0;
      period_meas_q <= 32'd0;
      eval_q        <= 1'b0;
      cand_q        <= 4'd0;
      note_code_q   <= 4'd0;
      note_valid_q  <= 1'b0;
      note_strobe_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      tone_dly_q    <= tone_dly_d;
      pcnt_q        <= pcnt_d;
      period_meas_q <= period_meas_d;
      eval_q        <= eval_d;
      cand_q        <= cand_d;
      note_code_q   <= note_code_d;
      note_valid_q  <= note_valid_d;
      note_strobe_q <= note_strobe_d;
    end
  end

  assign bus.note_code   = note_code_q;
  assign bus.note_valid  = note_valid_q;
  assign bus.note_strobe = note_strobe_q;
  assign bus.period_meas = period_meas_q;

endmodule

// File: tb/tb_tone_period_decoder.sv
// Randomized bench: a period-level reference model predicts every note change,
// and a monitor matches each note_strobe against the expected-change queue.
module tb_tone_period_decoder;

  localparam int SIL = 40000;
  localparam int TOL = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  tone_period_decoder_if bus ();

  tone_period_decoder #(.TOL(TOL), .SILENCE_CYC(SIL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int nominal [1:15] = '{95557, 85131, 75843, 71607, 63776, 56818, 50619, 47778,
                         42564, 37922, 35794, 31888, 28409, 25310, 23889};

  typedef struct {
    int code;
    int at_cyc;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model state, advanced once per rising edge driven on the pin
  bit active = 0;
  bit have_prev = 0;
  int prev_m = 0;
  int note = 0;
  int exp_pm = 0;
  int last_rise = 0;

  function automatic int match_of(input int p);
    for (int k = 1; k <= 15; k++) begin
      int d;
      d = (p > nominal[k]) ? p - nominal[k] : nominal[k] - p;
      if (d <= TOL) return k;
    end
    return 0;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.note_strobe === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected actual code=%0d cyc=%0d required no strobe",
                 bus.note_code, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.note_code != 4'(mon_e.code) || bus.note_valid != (mon_e.code != 0) ||
            cyc != mon_e.at_cyc) begin
          errors++;
          $display("FAIL strobe actual code=%0d valid=%0d cyc=%0d required code=%0d valid=%0d cyc=%0d",
                   bus.note_code, bus.note_valid, cyc, mon_e.code, mon_e.code != 0, mon_e.at_cyc);
        end else begin
          $display("strobe code=%0d cyc=%0d ok", mon_e.code, cyc);
        end
      end
    end
  end

  // Note changes when the two most recent periods since silence decode to the same code.
  task automatic model_rise();
    int gap;
    int m;
    gap = cyc - last_rise;
    if (!active) begin
      active    = 1;
      have_prev = 0;
    end else begin
      m      = match_of(gap);
      exp_pm = gap;
      if (have_prev && m == prev_m && m != 0 && m != note) begin
        note = m;
        exp_q.push_back('{code: m, at_cyc: cyc + 4});
      end
      prev_m    = m;
      have_prev = 1;
    end
    last_rise = cyc;
  endtask

  task automatic rise();
    bus.tone_in = 1'b1;
    model_rise();
    repeat (5) @(negedge clk);
    chk("period_meas", int'(bus.period_meas), exp_pm);
    chk("note_code", int'(bus.note_code), note);
    chk("note_valid", int'(bus.note_valid), int'(note != 0));
    $display("edge cyc=%0d period_meas=%0d note_code=%0d", last_rise, bus.period_meas, bus.note_code);
  endtask

  task automatic play(input int gap);
    int h;
    h = $urandom_range(gap - 8, 8);
    while (cyc < last_rise + h) @(negedge clk);
    bus.tone_in = 1'b0;
    while (cyc < last_rise + gap) @(negedge clk);
    rise();
  endtask

  task automatic stop_tone();
    int old_note;
    while (cyc < last_rise + 100) @(negedge clk);
    bus.tone_in = 1'b0;
    old_note = note;
    if (active && note != 0) exp_q.push_back('{code: 0, at_cyc: last_rise + 3 + SIL});
    while (cyc < last_rise + SIL - 2) @(negedge clk);
    chk("pre_timeout_code", int'(bus.note_code), old_note);
    while (cyc < last_rise + SIL + 10) @(negedge clk);
    active = 0;
    note   = 0;
    chk("timeout_code", int'(bus.note_code), 0);
    chk("timeout_valid", int'(bus.note_valid), 0);
    $display("silence cyc=%0d note_code=%0d", cyc, bus.note_code);
  endtask

  task automatic do_reset();
    bus.tone_in = 1'b0;
    rst = 1'b1;
    chk("pending_before_reset", exp_q.size(), 0);
    exp_q.delete();
    active    = 0;
    have_prev = 0;
    note      = 0;
    exp_pm    = 0;
    @(negedge clk);
    chk("rst_note_code", int'(bus.note_code), 0);
    chk("rst_note_valid", int'(bus.note_valid), 0);
    chk("rst_note_strobe", int'(bus.note_strobe), 0);
    chk("rst_period_meas", int'(bus.period_meas), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    $display("reset released cyc=%0d", cyc);
  endtask

  initial begin
    int k;
    int p;
    bus.tone_in = 1'b0;
    @(negedge clk);
    do_reset();

    // Long silence: nothing may change
    repeat (SIL + 5000) @(negedge clk);
    chk("idle_code", int'(bus.note_code), 0);
    chk("idle_valid", int'(bus.note_valid), 0);

    // Lock code 10, then switch to code 15
    rise();
    play(37922);
    play(37922);
    play(37922);
    play(23889);
    play(23889);

    // Non-matching period holds the note; tolerance boundary around code 14
    play(30000);
    play(25310 + 256);
    play(25310 + 256);
    play(25310 + 257);
    play(25310 - 256);
    // Edge exactly on the timeout cycle keeps the note
    play(SIL);

    // Random tones with jitter that sometimes exceeds the tolerance
    k = 12;
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(2, 0) == 0) k = $urandom_range(15, 10);
      p = nominal[k] + $urandom_range(600, 0) - 300;
      play(p);
    end

    stop_tone();

    // Reset while code 12 is locked, then re-lock
    rise();
    play(31888);
    play(31888);
    chk("locked_before_reset", int'(bus.note_code), 12);
    while (cyc < last_rise + 1000) @(negedge clk);
    bus.tone_in = 1'b0;
    repeat (50) @(negedge clk);
    do_reset();
    repeat (100) @(negedge clk);
    rise();
    play(31888);
    play(31888);

    repeat (10) @(negedge clk);
    chk("pending_at_end", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #(64'd20_000_000);
    $display("FAIL watchdog actual=timeout required=finish (cyc %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
